// File: rtl/mem_pkg.sv
// Shared SRAM command types, widths and the rotating-priority grant function.
package mem_pkg;
  localparam int MEM_AW  = 4;
  localparam int MEM_DW  = 8;
  localparam int MAX_REQ = 4;

  typedef struct packed {
    logic              we;
    logic [MEM_AW-1:0] addr;
    logic [MEM_DW-1:0] wdata;
  } mem_cmd_t;

  // First set bit of req at or after ptr, wrapping at n; bits at or above n are ignored.
  function automatic logic [MAX_REQ-1:0] rr_grant(input logic [MAX_REQ-1:0] req,
                                                  input logic [1:0]         ptr,
                                                  input logic [2:0]         n);
    logic [MAX_REQ-1:0] gnt;
    logic [2:0]         idx;
    gnt = '0;
    // Walk from the farthest offset down so the nearest requester wins last.
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + 3'(k);
      if (idx >= n) idx = idx - n;
      if ((3'(k) < n) && req[idx[1:0]]) begin
        gnt = '0;
        gnt[idx[1:0]] = 1'b1;
      end
    end
    return gnt;
  endfunction
endpackage

// File: rtl/sram_arb_pick.sv
// One-hot picker: first asserted request at or after ptr, with wrap-around.
module sram_arb_pick
  import mem_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);
  logic [MAX_REQ-1:0] req_x, gnt_x;
  logic               unused_gnt;

  always_comb begin
    req_x            = '0;
    req_x[NREQ-1:0]  = req;
  end

  assign gnt_x      = rr_grant(req_x, 2'(ptr), 3'(NREQ));
  assign gnt        = gnt_x[NREQ-1:0];
  assign unused_gnt = ^gnt_x;
endmodule

// File: rtl/sram_arbiter.sv
// NREQ-port arbiter in front of a single-port SRAM, 1-cycle read return.
// Define SRAM_ARB_RR_EN for round-robin; otherwise fixed priority (port 0 highest).
module sram_arbiter
  import mem_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic     [NREQ-1:0]        req_valid,
  input  mem_cmd_t [NREQ-1:0]        req_cmd,
  output logic     [NREQ-1:0]        req_ready,
  output logic     [NREQ-1:0]        rsp_valid,
  output logic     [MEM_DW-1:0]      rsp_data,
  output mem_cmd_t                   mem_cmd,
  input  logic     [MEM_DW-1:0]      mem_rdata
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] pick_gnt, gnt;
  logic [PW-1:0]   ptr, gidx, pend_id;
  logic            pend;

  sram_arb_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .gnt (pick_gnt)
  );

  assign gnt       = rst ? '0 : pick_gnt;
  assign req_ready = gnt;

  always_comb begin
    gidx    = '0;
    mem_cmd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gidx    = PW'(i);
        mem_cmd = req_cmd[i];
      end
    end
  end

`ifdef SRAM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst)        ptr <= '0;
    else if (|gnt)  ptr <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
  end
`else
  assign ptr = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pend    <= 1'b0;
      pend_id <= '0;
    end else begin
      pend    <= (|gnt) & ~mem_cmd.we;
      pend_id <= gidx;
    end
  end

  // A read issued just before reset must not surface while reset is held.
  always_comb begin
    for (int i = 0; i < NREQ; i++)
      rsp_valid[i] = pend & ~rst & (pend_id == PW'(i));
  end

  assign rsp_data = (|rsp_valid) ? mem_rdata : '0;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM model on the command port plus a response scoreboard.
module tb_sram_arbiter;
  import mem_pkg::*;

  localparam int N = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_ready, rsp_valid;
  mem_cmd_t [N-1:0]  req_cmd;
  logic [7:0]        rsp_data, mem_rdata;
  mem_cmd_t          mem_cmd;

  logic [3:0]        v4, r4, rv4;
  mem_cmd_t [3:0]    c4;
  logic [7:0]        rd4, rdat4;
  mem_cmd_t          mc4;

  logic [7:0]        sram [16];
  int                tests = 0, fails = 0, cyc = 0;

  typedef struct { int port; logic [7:0] data; int due; } exp_t;
  exp_t sb[$];

  sram_arbiter #(.NREQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_cmd(req_cmd),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_cmd(mem_cmd), .mem_rdata(mem_rdata));

  sram_arbiter #(.NREQ(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(v4), .req_cmd(c4),
    .req_ready(r4), .rsp_valid(rv4), .rsp_data(rdat4),
    .mem_cmd(mc4), .mem_rdata(rd4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM command block: registered read, write-through visible next cycle.
  initial for (int i = 0; i < 16; i++) sram[i] = 8'h00;
  always @(posedge clk) begin
    if (mem_cmd.we) sram[mem_cmd.addr] <= mem_cmd.wdata;
    mem_rdata <= sram[mem_cmd.addr];
  end

  // Response monitor: every cycle, rsp must match the scoreboard head if it is due now.
  always @(negedge clk) begin
    logic [N-1:0] ev;
    logic [7:0]   ed;
    ev = '0;
    ed = 8'h00;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      ev[sb[0].port] = 1'b1;
      ed = sb[0].data;
      void'(sb.pop_front());
    end
    tests++;
    if (rsp_valid !== ev || rsp_data !== ed) begin
      fails++;
      $display("FAIL rsp cyc=%0d got valid=%b data=%h want valid=%b data=%h",
               cyc, rsp_valid, rsp_data, ev, ed);
    end
  end

  function automatic mem_cmd_t mk(input logic we, input logic [3:0] a, input logic [7:0] d);
    mem_cmd_t c;
    c.we = we; c.addr = a; c.wdata = d;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b11;
    req_cmd[0] = mk(1'b0, 4'd1, 8'h00); req_cmd[1] = mk(1'b0, 4'd2, 8'h00);
    v4 = 4'b0000; c4 = '0; rd4 = 8'h00;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (req_ready !== 2'b00 || mem_cmd !== '0) begin
        fails++;
        $display("FAIL reset_outputs got ready=%b cmd=%h want ready=00 cmd=0", req_ready, mem_cmd);
      end
      tick();
    end
    // First cycle out of reset must already grant.
    rst = 1'b0; req_valid = 2'b01; req_cmd[0] = mk(1'b1, 4'd0, 8'h11);
    @(negedge clk);
    tests++;
    if (req_ready !== 2'b01 || mem_cmd !== mk(1'b1, 4'd0, 8'h11)) begin
      fails++;
      $display("FAIL first_grant got ready=%b cmd=%h want ready=01 cmd=%h", req_ready, mem_cmd, mk(1'b1, 4'd0, 8'h11));
    end
    tick();
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_write_read();
    req_valid = 2'b01; req_cmd[0] = mk(1'b1, 4'd3, 8'h55);
    @(negedge clk);
    tests++;
    if (req_ready !== 2'b01 || mem_cmd !== mk(1'b1, 4'd3, 8'h55)) begin
      fails++;
      $display("FAIL wr_grant got ready=%b cmd=%h want ready=01", req_ready, mem_cmd);
    end
    tick();
    req_valid = 2'b10; req_cmd[1] = mk(1'b0, 4'd3, 8'h00);
    @(negedge clk);
    tests++;
    if (req_ready !== 2'b10 || mem_cmd !== mk(1'b0, 4'd3, 8'h00)) begin
      fails++;
      $display("FAIL rd_grant got ready=%b cmd=%h want ready=10", req_ready, mem_cmd);
    end
    sb.push_back('{port: 1, data: 8'h55, due: cyc + 1});
    tick();
    req_valid = 2'b00;
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq_v [3] = '{2'b01, 2'b10, 2'b01};
    req_cmd[0] = mk(1'b1, 4'd5, 8'h77);
    req_cmd[1] = mk(1'b0, 4'd5, 8'h00);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) req_cmd[0] = mk(1'b0, 4'd3, 8'h00);
      req_valid = seq_v[k];
      @(negedge clk);
      tests++;
      if (req_ready !== seq_v[k]) begin
        fails++;
        $display("FAIL b2b_grant k=%0d got %b want %b", k, req_ready, seq_v[k]);
      end
      if (k == 1) sb.push_back('{port: 1, data: 8'h77, due: cyc + 1});
      if (k == 2) sb.push_back('{port: 0, data: 8'h55, due: cyc + 1});
      tick();
    end
    req_valid = 2'b00;
    tick(); tick();
  endtask

  task automatic test_rst_read();
    req_valid = 2'b01; req_cmd[0] = mk(1'b0, 4'd3, 8'h00);
    @(negedge clk);
    tests++;
    if (req_ready !== 2'b01) begin
      fails++;
      $display("FAIL rst_read_grant got %b want 01", req_ready);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (req_ready !== 2'b00) begin
      fails++;
      $display("FAIL rst_read_ready got %b want 00", req_ready);
    end
    tick();
    rst = 1'b0; req_valid = 2'b00;
    tick();
  endtask

  task automatic test_rotation();
    logic [1:0] exp_g [6];
`ifdef SRAM_ARB_RR_EN
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
`endif
    req_cmd[0] = mk(1'b0, 4'd3, 8'h00);
    req_cmd[1] = mk(1'b0, 4'd5, 8'h00);
    req_valid  = 2'b11;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      tests++;
      if (req_ready !== exp_g[k] || mem_cmd !== req_cmd[exp_g[k][1]]) begin
        fails++;
        $display("FAIL rotate k=%0d got ready=%b cmd=%h want ready=%b", k, req_ready, mem_cmd, exp_g[k]);
      end
      if (exp_g[k] == 2'b01) sb.push_back('{port: 0, data: 8'h55, due: cyc + 1});
      else                   sb.push_back('{port: 1, data: 8'h77, due: cyc + 1});
      tick();
    end
    req_valid = 2'b00;
    tick(); tick();
  endtask

  task automatic test_four_port();
    logic [3:0] vin [4] = '{4'b0010, 4'b1010, 4'b1010, 4'b0011};
    logic [3:0] exp_g [4];
`ifdef SRAM_ARB_RR_EN
    exp_g = '{4'b0010, 4'b1000, 4'b0010, 4'b0001};
`else
    exp_g = '{4'b0010, 4'b0010, 4'b0010, 4'b0001};
`endif
    for (int i = 0; i < 4; i++) c4[i] = mk(1'b1, 4'(i), 8'(8'hA0 + i));
    for (int k = 0; k < 4; k++) begin
      v4 = vin[k];
      @(negedge clk);
      tests++;
      if (r4 !== exp_g[k] || rv4 !== 4'b0000) begin
        fails++;
        $display("FAIL four_port k=%0d got ready=%b rsp=%b want ready=%b rsp=0000", k, r4, rv4, exp_g[k]);
      end
      tick();
    end
    v4 = 4'b0000;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_cmd = '0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_rst_read();
    test_rotation();
    test_four_port();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish want finish before 100000");
    $fatal(1, "timeout");
  end
endmodule
